// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: access size codes, default depth
// and a pointer-width helper.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SRAM_SIZE_B = 2'd0,
    SRAM_SIZE_H = 2'd1,
    SRAM_SIZE_W = 2'd2
  } sram_size_e;

  localparam int DSRAM_DEPTH_LOG2 = 12;

  // Queue pointers keep at least one bit even for a single-entry queue.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response queue of {rdata, countdown}. Exposes the head it will hold after
// this edge so the top can register data_ok/rdata without adding a cycle.
module sram_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter  int MAX_OUTST = 4,
  parameter  int LATENCY   = 2,
  localparam int PW        = ptr_width(MAX_OUTST),
  localparam int CW        = $clog2(LATENCY + 1),
  localparam int NW        = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic [31:0]   push_data_i,
  input  logic          pop_i,
  output logic [NW-1:0] count_o,
  output logic          nxt_vld_o,
  output logic          nxt_rdy_o,
  output logic [31:0]   nxt_data_o
);

  logic [MAX_OUTST-1:0][31:0]   data_q;
  logic [MAX_OUTST-1:0][CW-1:0] cd_q;
  logic [PW-1:0]                rd_q, rd_d, wr_q;
  logic [NW-1:0]                cnt_q, cnt_d, kept;
  logic                         pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - CW'(1);
  endfunction

  assign pop       = pop_i && (cnt_q != '0);
  assign rd_d      = pop ? inc(rd_q) : rd_q;
  assign kept      = cnt_q - NW'(pop);
  assign cnt_d     = kept + NW'(push_i);
  assign nxt_vld_o = (cnt_d != '0);
  assign count_o   = cnt_q;

  // With nothing left behind the pop, the next head is the entry being pushed.
  always_comb begin
    nxt_data_o = push_data_i;
    nxt_rdy_o  = (LATENCY == 1);
    if (kept != '0) begin
      nxt_data_o = data_q[rd_d];
      nxt_rdy_o  = (dec(cd_q[rd_d]) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i) wr_q <= inc(wr_q);
    end
  end

  // Payload needs no reset: slots outside the live window are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTST; i++) cd_q[i] <= dec(cd_q[i]);
    if (push_i) begin
      data_q[wr_q] <= push_data_i;
      cd_q[wr_q]   <= CW'(LATENCY - 1);
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Slave end of the data-SRAM port: word array with byte-lane stores, in-order
// responses after a fixed minimum latency, up to MAX_OUTST requests in flight.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter  int DEPTH_LOG2 = DSRAM_DEPTH_LOG2,
  parameter  int LATENCY    = 2,
  parameter  int MAX_OUTST  = 4,
  localparam int NW         = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_i,
  input  logic          wr_i,
  input  logic [1:0]    size_i,
  input  logic [3:0]    wstrb_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic          addr_ok_o,
  output logic          data_ok_o,
  output logic [31:0]   rdata_o,
  input  logic          stall_addr_i,
  output logic [NW-1:0] outst_cnt_o
);

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic                  resetn_q, data_ok_q;
  logic [31:0]           rdata_q, push_data, nxt_data;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept, nxt_vld, nxt_rdy;
  logic                  unused_ok;

  // Lanes come from wstrb and the byte offset never selects a word.
  assign unused_ok = ^{size_i, addr_i[1:0], addr_i[31:DEPTH_LOG2+2]};

  assign idx       = addr_i[DEPTH_LOG2+1:2];
  assign addr_ok_o = resetn_q && !stall_addr_i && (outst_cnt_o < NW'(MAX_OUTST));
  assign accept    = req_i && addr_ok_o && resetn;
  assign push_data = wr_i ? '0 : mem[idx];

  always_ff @(posedge clk) begin
    if (accept && wr_i)
      for (int i = 0; i < 4; i++)
        if (wstrb_i[i]) mem[idx][8*i +: 8] <= wdata_i[8*i +: 8];
  end

  sram_resp_fifo #(
    .MAX_OUTST (MAX_OUTST),
    .LATENCY   (LATENCY)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (accept),
    .push_data_i (push_data),
    .pop_i       (data_ok_q),
    .count_o     (outst_cnt_o),
    .nxt_vld_o   (nxt_vld),
    .nxt_rdy_o   (nxt_rdy),
    .nxt_data_o  (nxt_data)
  );

  always_ff @(posedge clk) begin
    resetn_q <= resetn;
    if (!resetn) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= nxt_vld && nxt_rdy;
      if (nxt_vld && nxt_rdy) rdata_q <= nxt_data;
    end
  end

  assign data_ok_o = data_ok_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: timestamped scoreboard of responses plus directed
// scenarios and a randomized traffic run.
module tb_data_sram_responder;
  localparam int DL = 4, LAT = 5, MO = 4, CNTW = $clog2(MO + 1), WORDS = 1 << DL;

  logic clk = 0, resetn = 0, req = 0, wr = 0, stall = 0;
  logic [1:0] size = 2'd2;
  logic [3:0] wstrb = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic addr_ok, data_ok;
  logic [CNTW-1:0] outst;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .MAX_OUTST(MO)) dut (
    .clk(clk), .resetn(resetn), .req_i(req), .wr_i(wr), .size_i(size), .wstrb_i(wstrb),
    .addr_i(addr), .wdata_i(wdata), .addr_ok_o(addr_ok), .data_ok_o(data_ok),
    .rdata_o(rdata), .stall_addr_i(stall), .outst_cnt_o(outst));

  // Reference: each accepted request is due exactly LAT cycles after its accept cycle.
  typedef struct { logic [31:0] d; int due; } exp_t;
  exp_t q[$];
  logic [31:0] mem [WORDS];
  int cyc = 0, acc_cyc = 0;
  bit m_rq = 0, m_dok = 0, m_acc = 0;
  logic [31:0] m_rdata = 0;

  always @(posedge clk) begin
    exp_t e;
    int w;
    m_acc = resetn && req && m_rq && !stall && (q.size() < MO);
    if (!resetn) begin
      q.delete(); m_dok = 0; m_rdata = 0;
    end else begin
      if (m_dok) void'(q.pop_front());
      if (m_acc) begin
        w = int'(addr[DL+1:2]);
        acc_cyc = cyc;
        e.due = cyc + LAT;
        e.d = 32'h0;
        if (wr) begin
          for (int b = 0; b < 4; b++) if (wstrb[b]) mem[w][8*b +: 8] = wdata[8*b +: 8];
        end else e.d = mem[w];
        q.push_back(e);
      end
      m_dok = (q.size() > 0) && (q[0].due == cyc + 1);
      if (m_dok) m_rdata = q[0].d;
    end
    m_rq = resetn;
    cyc++;
  end

  logic [31:0] rsp_log[$];
  always @(negedge clk) if (data_ok) rsp_log.push_back(rdata);

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req = 1; wr = w; addr = a; wstrb = s; wdata = d;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_acc) begin req = 0; return; end
    end
    req = 0; checks++; errors++;
    $display("FAIL accept_timeout addr=%h not accepted within 40 cycles", a);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (outst == 0) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL drain_timeout outst=%0d required 0", outst);
  endtask

  task automatic test_reset();
    resetn = 0;
    repeat (3) tick();
    checks += 4;
    if (addr_ok !== 1'b0) begin errors++; $display("FAIL rst_addr_ok got %b want 0", addr_ok); end
    if (data_ok !== 1'b0) begin errors++; $display("FAIL rst_data_ok got %b want 0", data_ok); end
    if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
    if (outst !== '0) begin errors++; $display("FAIL rst_outst got %0d want 0", outst); end
    resetn = 1; #1;
    checks++;
    if (addr_ok !== 1'b0) begin errors++; $display("FAIL rel_addr_ok got %b want 0", addr_ok); end
    tick();
    checks++;
    if (addr_ok !== 1'b1) begin errors++; $display("FAIL post_rel_addr_ok got %b want 1", addr_ok); end
  endtask

  // Store then load the same word back-to-back; load answers exactly LAT cycles after accept.
  task automatic test_store_load(input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] d, input logic [31:0] want, input string nm);
    int t;
    issue(1, a, s, d);
    issue(0, {a[31:2], 2'b00}, 4'h0, 32'h0);
    t = acc_cyc;
    while (cyc < t + LAT - 1) tick();
    checks++;
    if (data_ok !== 1'b1 || rdata !== 32'h0) begin
      errors++; $display("FAIL %s_store_rsp got ok=%b %h want ok=1 00000000", nm, data_ok, rdata);
    end
    tick();
    checks++;
    if (data_ok !== 1'b1 || rdata !== want) begin
      errors++; $display("FAIL %s_load_rsp got ok=%b %h want ok=1 %h", nm, data_ok, rdata, want);
    end
    tick();
    checks++;
    if (data_ok !== 1'b0) begin errors++; $display("FAIL %s_tail got data_ok=%b want 0", nm, data_ok); end
  endtask

  task automatic test_fill();
    rsp_log.delete();
    for (int i = 0; i < WORDS; i++) issue(1, 32'(i * 4), 4'hF, $urandom);
    wait_idle();
    checks++;
    if (rsp_log.size() != WORDS) begin
      errors++; $display("FAIL fill_count got %0d want %0d", rsp_log.size(), WORDS);
    end
    foreach (rsp_log[i]) begin
      checks++;
      if (rsp_log[i] !== 32'h0) begin errors++; $display("FAIL fill_rdata[%0d] got %h want 0", i, rsp_log[i]); end
    end
  endtask

  task automatic test_full_queue();
    logic [31:0] exp_q[$], a[6];
    int issued = 0, peak = 0;
    bit blocked = 0;
    rsp_log.delete();
    for (int i = 0; i < 6; i++) begin
      a[i] = 32'($urandom_range(0, WORDS - 1) * 4);
      exp_q.push_back(mem[a[i][DL+1:2]]);
    end
    req = 1; wr = 0; addr = a[0];
    for (int c = 0; c < 80 && (issued < 6 || outst != 0); c++) begin
      if (req && !addr_ok) blocked = 1;
      tick();
      if (m_acc) begin
        issued++;
        if (issued < 6) addr = a[issued]; else req = 0;
      end
      if (int'(outst) > peak) peak = int'(outst);
    end
    req = 0;
    checks += 5;
    if (issued != 6) begin errors++; $display("FAIL full_issued got %0d want 6", issued); end
    if (peak != MO) begin errors++; $display("FAIL full_peak got %0d want %0d", peak, MO); end
    if (!blocked) begin errors++; $display("FAIL full_block got addr_ok never low want low when full"); end
    if (outst !== '0) begin errors++; $display("FAIL full_drain got %0d want 0", outst); end
    if (rsp_log.size() != 6) begin errors++; $display("FAIL full_rsp_count got %0d want 6", rsp_log.size()); end
    for (int i = 0; i < 6 && i < rsp_log.size(); i++) begin
      checks++;
      if (rsp_log[i] !== exp_q[i]) begin errors++; $display("FAIL full_order[%0d] got %h want %h", i, rsp_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_hazard();
    logic [31:0] want[4];
    want[0] = 32'h0; want[1] = 32'h11111111; want[2] = 32'h0; want[3] = 32'h22222222;
    wait_idle();
    issue(1, 32'h20, 4'hF, 32'h11111111);
    wait_idle();
    rsp_log.delete();
    issue(0, 32'h20, 4'h0, 32'h0);
    issue(1, 32'h20, 4'hF, 32'h22222222);
    issue(0, 32'h20, 4'h0, 32'h0);
    wait_idle();
    rsp_log.push_front(32'h0);
    checks++;
    if (rsp_log.size() != 4) begin errors++; $display("FAIL hazard_count got %0d want 4", rsp_log.size()); end
    for (int i = 1; i < 4 && i < rsp_log.size(); i++) begin
      checks++;
      if (rsp_log[i] !== want[i]) begin errors++; $display("FAIL hazard[%0d] got %h want %h", i, rsp_log[i], want[i]); end
    end
  endtask

  task automatic test_stall();
    wait_idle();
    stall = 1; req = 1; wr = 0; addr = 32'h20; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_ok !== 1'b0) begin errors++; $display("FAIL stall_addr_ok[%0d] got %b want 0", i, addr_ok); end
      tick();
      checks += 2;
      if (outst !== '0) begin errors++; $display("FAIL stall_outst[%0d] got %0d want 0", i, outst); end
      if (data_ok !== 1'b0) begin errors++; $display("FAIL stall_data_ok[%0d] got %b want 0", i, data_ok); end
    end
    stall = 0; #1;
    checks++;
    if (addr_ok !== 1'b1) begin errors++; $display("FAIL unstall_addr_ok got %b want 1", addr_ok); end
    tick();
    req = 0;
    checks++;
    if (outst !== CNTW'(1)) begin errors++; $display("FAIL unstall_accept got outst=%0d want 1", outst); end
    rsp_log.delete();
    wait_idle();
    checks++;
    if (rsp_log.size() != 1 || rsp_log[0] !== 32'h22222222) begin
      errors++; $display("FAIL unstall_rsp got n=%0d want one 22222222", rsp_log.size());
    end
  endtask

  task automatic test_random();
    logic exp_ok;
    for (int c = 0; c < 250; c++) begin
      req = ($urandom_range(0, 3) != 0); wr = $urandom_range(0, 1);
      addr = $urandom; wstrb = 4'($urandom); wdata = $urandom;
      stall = ($urandom_range(0, 7) == 0); #1;
      exp_ok = m_rq && !stall && (q.size() < MO);
      checks++;
      if (addr_ok !== exp_ok) begin errors++; $display("FAIL rnd_addr_ok c=%0d got %b want %b", c, addr_ok, exp_ok); end
      tick();
      checks += 2;
      if (data_ok !== m_dok) begin errors++; $display("FAIL rnd_data_ok c=%0d got %b want %b", c, data_ok, m_dok); end
      if (outst !== CNTW'(q.size())) begin errors++; $display("FAIL rnd_outst c=%0d got %0d want %0d", c, outst, q.size()); end
      if (m_dok) begin
        checks++;
        if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, rdata, m_rdata); end
      end
    end
    req = 0; stall = 0;
    wait_idle();
  endtask

  task automatic test_reset_inflight();
    int n;
    wait_idle();
    issue(0, 32'h0, 4'h0, 32'h0);
    issue(0, 32'h4, 4'h0, 32'h0);
    issue(0, 32'h8, 4'h0, 32'h0);
    checks++;
    if (outst !== CNTW'(3)) begin errors++; $display("FAIL inflight_outst got %0d want 3", outst); end
    n = rsp_log.size();
    resetn = 0;
    tick();
    checks += 3;
    if (data_ok !== 1'b0) begin errors++; $display("FAIL rst_mid_data_ok got %b want 0", data_ok); end
    if (outst !== '0) begin errors++; $display("FAIL rst_mid_outst got %0d want 0", outst); end
    if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata got %h want 0", rdata); end
    tick();
    checks++;
    if (addr_ok !== 1'b0) begin errors++; $display("FAIL rst_mid_addr_ok got %b want 0", addr_ok); end
    resetn = 1;
    repeat (12) tick();
    checks += 2;
    if (rsp_log.size() != n) begin errors++; $display("FAIL stale_rsp got %0d responses want 0", rsp_log.size() - n); end
    if (outst !== '0) begin errors++; $display("FAIL post_rst_outst got %0d want 0", outst); end
  endtask

  initial begin
    test_reset();
    test_store_load(32'h10, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, "word");
    test_store_load(32'h11, 4'b0010, 32'h0000AA00, 32'hDEADAAEF, "byte");
    test_fill();
    test_full_queue();
    test_hazard();
    test_stall();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
